// File: rtl/bit_serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands one bit per clock, LSB first,
// through a single full-adder cell and a carry flop.
module bit_serial_adder #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] Input_1,
    input  logic [WIDTH-1:0] Input_2,
    input  logic             Carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             Carry,
    output logic             Overflow,
    output logic [1:0]       dbg_state
);

    // Handshake: start is honoured only in IDLE (busy=0, done=0); done is a
    // one-cycle pulse and Result/Carry/Overflow are valid from it until the next start.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_nxt;
    logic             c;
    logic             c_nxt;
    logic             s;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
            end
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Full-adder cell on the current LSBs
    always_comb begin
        s       = a_sh[0] ^ b_sh[0] ^ c;
        c_nxt   = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
        sum_nxt = {s, sum_sh[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            sum_sh   <= '0;
            c        <= 1'b0;
            cnt      <= '0;
            Result   <= '0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
        end else if (load) begin
            a_sh   <= Input_1;
            b_sh   <= Input_2;
            c      <= Carry_in;
            cnt    <= '0;
            sum_sh <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_nxt;
            c      <= c_nxt;
            cnt    <= cnt + 1'b1;
            // On the MSB step c is the carry into the MSB, so the visible
            // outputs are taken from this cycle's adder results directly.
            if (cnt == LAST) begin
                Result   <= sum_nxt;
                Carry    <= c_nxt;
                Overflow <= c ^ c_nxt;
            end
        end
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Bench for bit_serial_adder (WIDTH=8): directed vectors with literal
// expectations plus a cycle-level arithmetic model checked every cycle.
module tb_bit_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] Input_1 = '0;
    logic [W-1:0] Input_2 = '0;
    logic         Carry_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] Result;
    logic         Carry;
    logic         Overflow;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .Input_1   (Input_1),
        .Input_2   (Input_2),
        .Carry_in  (Carry_in),
        .busy      (busy),
        .done      (done),
        .Result    (Result),
        .Carry     (Carry),
        .Overflow  (Overflow),
        .dbg_state (dbg_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model: an accepted request produces A+B+Cin after W busy cycles.
    int           run_left = 0;
    bit           m_done = 1'b0;
    logic [W-1:0] exp_res = '0;
    logic         exp_c = 1'b0;
    logic         exp_ov = 1'b0;
    logic [W-1:0] pend_res;
    logic         pend_c;
    logic         pend_ov;
    logic [W:0]   full_sum;

    always @(posedge clk) begin
        if (!rst) begin
            run_left = 0;
            m_done   = 1'b0;
            exp_res  = '0;
            exp_c    = 1'b0;
            exp_ov   = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (run_left > 0) begin
            run_left--;
            if (run_left == 0) begin
                m_done  = 1'b1;
                exp_res = pend_res;
                exp_c   = pend_c;
                exp_ov  = pend_ov;
            end
        end else if (start) begin
            run_left = W;
            full_sum = {1'b0, Input_1} + {1'b0, Input_2} + {{W{1'b0}}, Carry_in};
            pend_res = full_sum[W-1:0];
            pend_c   = full_sum[W];
            pend_ov  = (Input_1[W-1] == Input_2[W-1]) && (full_sum[W-1] != Input_1[W-1]);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", busy, run_left > 0);
            check("done", done, m_done);
            check("result", Result, exp_res);
            check("carry", Carry, exp_c);
            check("overflow", Overflow, exp_ov);
        end
    end

    // mode 0: plain; 1: scramble operands during RUN; 2: re-pulse start mid-RUN
    task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic [W-1:0] er, input logic ec, input logic eov, input int mode);
        int lat;
        int busy_cnt;
        bit got;
        @(posedge clk); #1;
        Input_1 = a; Input_2 = b; Carry_in = cin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; busy_cnt = 0; got = 1'b0;
        while (!got && lat < 4 * W) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cnt++;
            if (done) got = 1'b1;
            if (mode == 1) begin
                Input_1 = ~Input_1 ^ W'($urandom_range(0, 255));
                Input_2 = W'($urandom_range(0, 255));
                Carry_in = ~Carry_in;
            end
            if (mode == 2 && lat == 3) begin
                Input_1 = 8'hAA; Input_2 = 8'hAA; start = 1'b1;
            end
            if (mode == 2 && lat == 4) start = 1'b0;
        end
        check("done_seen", got, 1'b1);
        check("latency", lat, W + 1);
        check("busy_cycles", busy_cnt, W);
        check("lit_result", Result, er);
        check("lit_carry", Carry, ec);
        check("lit_overflow", Overflow, eov);
        if (mode == 2) begin
            repeat (3) begin
                @(negedge clk);
                check("hold_result", Result, er);
            end
        end
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W:0]   rs;
        int           done_cnt;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", Result, 0);
        check("rst_carry", Carry, 1'b0);
        check("rst_overflow", Overflow, 1'b0);
        rst = 1'b1;
        cmp_en = 1'b1;

        do_add(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 0);
        do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        do_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
        do_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0);
        do_add(8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0, 1);
        do_add(8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0, 2);
        do_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0);

        // Reset in the middle of an operation
        @(posedge clk); #1;
        Input_1 = 8'h12; Input_2 = 8'h34; Carry_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_result", Result, 0);
        check("mid_rst_carry", Carry, 1'b0);
        check("mid_rst_overflow", Overflow, 1'b0);
        rst = 1'b1;
        done_cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("no_done_after_rst", done_cnt, 0);
        do_add(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 0);

        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            rs = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            do_add(ra, rb, rc, rs[W-1:0], rs[W],
                   (ra[W-1] == rb[W-1]) && (rs[W-1] != ra[W-1]), 0);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
